// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: bus width, region codes and
// region base addresses, plus small decode helpers used by the top level.
package mmio_responder_pkg;

    localparam int BUS_W = 32;

    // Region select lives in the two most significant address bits.
    typedef enum logic [1:0] {
        REGION_MEM  = 2'b00,
        REGION_LED  = 2'b01,
        REGION_SW   = 2'b10,
        REGION_NONE = 2'b11
    } region_e;

    localparam logic [BUS_W-1:0] MEM_BASE = 32'h0000_0000;
    localparam logic [BUS_W-1:0] LED_BASE = 32'h4000_0000;
    localparam logic [BUS_W-1:0] SW_BASE  = 32'h8000_0000;

    // Region code of a byte address.
    function automatic region_e region_of(input logic [BUS_W-1:0] addr);
        return region_e'(addr[31:30]);
    endfunction

    // True when the address is word aligned.
    function automatic logic is_aligned(input logic [BUS_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mmio_responder_switch_debouncer.sv
// switch_debouncer: two-flop synchroniser followed by a stability counter.
// A synchronised value must remain unchanged for DEBOUNCE_CYCLES cycles
// before it replaces the accepted (debounced) value.
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous active-low reset
//  switches     in   SW_W  raw asynchronous switch inputs
//  debounced    out  SW_W  accepted switch value
module switch_debouncer #(
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] switches,
    output logic [SW_W-1:0] debounced
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync1_q, sync1_d;
    logic [SW_W-1:0]  sync2_q, sync2_d;
    logic [SW_W-1:0]  cand_q,  cand_d;
    logic [SW_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state for synchroniser, candidate, counter and accepted value.
    always_comb begin
        sync1_d = switches;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (sync2_q != cand_q) begin
            // Any movement restarts the stability window on the new value.
            cand_d = sync2_q;
            cnt_d  = {CNT_W{1'b0}};
        end else if (cand_q != acc_q) begin
            if (cnt_q >= CNT_LAST) begin
                acc_d = cand_q;
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= {SW_W{1'b0}};
            sync2_q <= {SW_W{1'b0}};
            cand_q  <= {SW_W{1'b0}};
            acc_q   <= {SW_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign debounced = acc_q;

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: responder side of the single-master memory-mapped bus.
// Decodes accesses to data memory, LED register and debounced switches and
// returns registered read data one cycle after the request.
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous active-low reset
//  address      in   32     byte address
//  readEnable   in   1      read request
//  writeEnable  in   1      write request
//  writeData    in   32     write data
//  readData     out  32     registered read data
//  readValid    out  1      pulse: readData answers the previous cycle's read
//  accessError  out  1      pulse: previous cycle's access was rejected
//  switches     in   SW_W   raw board switches
//  leds         out  LED_W  LED register
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int MEM_DEPTH       = 256,
    parameter int LED_W           = 16,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  address,
    input  logic              readEnable,
    input  logic              writeEnable,
    input  logic [BUS_W-1:0]  writeData,
    output logic [BUS_W-1:0]  readData,
    output logic              readValid,
    output logic              accessError,
    input  logic [SW_W-1:0]   switches,
    output logic [LED_W-1:0]  leds
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [BUS_W-1:0] mem_q [MEM_DEPTH];

    logic [BUS_W-1:0] read_data_q, read_data_d;
    logic             read_valid_q, read_valid_d;
    logic             access_error_q, access_error_d;
    logic [LED_W-1:0] leds_q, leds_d;

    region_e          region_s;
    logic [IDX_W-1:0] mem_idx_s;
    logic             reject_s;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic             mem_we_s;
    logic [BUS_W-1:0] led_ext_s;
    logic [BUS_W-1:0] sw_ext_s;
    logic [SW_W-1:0]  sw_deb_s;
    logic             unused_addr_s;

    switch_debouncer #(
        .SW_W            (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_switch_debouncer (
        .clk       (clk),
        .rst       (rst),
        .switches  (switches),
        .debounced (sw_deb_s)
    );

    // Bits between the memory index and the region field only alias.
    assign unused_addr_s = ^address[29:IDX_W+2];

    // Decode, acceptance and response next-state.
    always_comb begin
        region_s       = region_of(address);
        mem_idx_s      = address[IDX_W+1:2];
        led_ext_s      = {BUS_W{1'b0}};
        led_ext_s[LED_W-1:0] = leds_q;
        sw_ext_s       = {BUS_W{1'b0}};
        sw_ext_s[SW_W-1:0]   = sw_deb_s;

        reject_s = (readEnable && writeEnable)
                || ((readEnable || writeEnable) && !is_aligned(address))
                || ((readEnable || writeEnable) && (region_s == REGION_NONE))
                || (writeEnable && (region_s == REGION_SW));
        rd_ok_s  = readEnable  && !reject_s;
        wr_ok_s  = writeEnable && !reject_s;
        mem_we_s = wr_ok_s && (region_s == REGION_MEM);

        leds_d         = leds_q;
        read_data_d    = read_data_q;
        read_valid_d   = rd_ok_s;
        access_error_d = reject_s;

        if (wr_ok_s && (region_s == REGION_LED)) begin
            leds_d = writeData[LED_W-1:0];
        end else begin
            leds_d = leds_q;
        end

        if (rd_ok_s) begin
            case (region_s)
                REGION_MEM: read_data_d = mem_q[mem_idx_s];
                REGION_LED: read_data_d = led_ext_s;
                REGION_SW:  read_data_d = sw_ext_s;
                default:    read_data_d = {BUS_W{1'b0}};
            endcase
        end else if (reject_s && readEnable) begin
            read_data_d = {BUS_W{1'b0}};
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Data memory: written at the sampling edge, deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_idx_s] <= writeData;
        end
    end

    // Response and LED registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_q    <= {BUS_W{1'b0}};
            read_valid_q   <= 1'b0;
            access_error_q <= 1'b0;
            leds_q         <= {LED_W{1'b0}};
        end else begin
            read_data_q    <= read_data_d;
            read_valid_q   <= read_valid_d;
            access_error_q <= access_error_d;
            leds_q         <= leds_d;
        end
    end

    assign readData    = read_data_q;
    assign readValid   = read_valid_q;
    assign accessError = access_error_q;
    assign leds        = leds_q;

endmodule
